// File: rtl/cfg_pkg.sv
// Shared types and constants for the switch-box configuration loader.
package cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StDone,
    StError
  } cfg_state_e;

  localparam int unsigned DefaultWordW = 8;

  // Config bits held by one switch box of the given wire count.
  function automatic int unsigned sb_cfg_bits(input int unsigned width);
    return width * 8;
  endfunction

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in serial-out word register; the MSB is the bit currently on the chain input.
module cfg_piso
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W = DefaultWordW
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [WORD_W-1:0] data_in,
  output logic              msb
);

  logic [WORD_W-1:0] shreg_q;

  // clear wins so a cancelled or finished word never leaks onto the chain input
  always_ff @(posedge clk) begin
    if (!nrst) begin
      shreg_q <= '0;
    end else if (clear) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= data_in;
    end else if (shift) begin
      shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
    end
  end

  assign msb = shreg_q[WORD_W-1];

endmodule

// File: rtl/cfg_loader.sv
// Configuration loader: streams word-wide bitstream MSB-first into a switch-box config chain
// and accumulates the parity of the previous image as it leaves the chain tail.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W    = DefaultWordW,
  parameter int unsigned CHAIN_LEN = sb_cfg_bits(32),
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_data_out,
  output logic              cfg_shift_en,
  output logic              cfg_mode,
  input  logic              chain_tail_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              rb_parity
);

  localparam int unsigned BitsW    = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WordCntW = $clog2(WORD_W + 1);
  localparam int unsigned WaitW    = $clog2(TIMEOUT + 1);

  cfg_state_e          state_q;
  logic [BitsW-1:0]    bits_left_q;
  logic [WordCntW-1:0] bits_in_word_q;
  logic [WaitW-1:0]    wait_q;
  logic [WordCntW-1:0] word_bits;
  logic                accept;
  logic                last_bit;
  logic                piso_clear;

  // Bits of the next word that actually reach the chain; the tail of a short last word is dropped.
  always_comb begin
    word_bits = WordCntW'(WORD_W);
    if (32'(bits_left_q) < WORD_W) begin
      word_bits = WordCntW'(bits_left_q);
    end
  end

  assign accept     = (state_q == StLoad) && word_valid && word_ready && !abort;
  assign last_bit   = (state_q == StShift) && (bits_in_word_q == WordCntW'(1));
  assign piso_clear = abort || last_bit;

  cfg_piso #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk     (clk),
    .nrst    (nrst),
    .load    (accept),
    .shift   (state_q == StShift),
    .clear   (piso_clear),
    .data_in (word_in),
    .msb     (cfg_data_out)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q        <= StIdle;
      word_ready     <= 1'b0;
      cfg_shift_en   <= 1'b0;
      cfg_mode       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      rb_parity      <= 1'b0;
      bits_left_q    <= '0;
      bits_in_word_q <= '0;
      wait_q         <= '0;
    end else if (abort) begin
      // error and rb_parity are left as they are; only the load is cancelled
      state_q        <= StIdle;
      word_ready     <= 1'b0;
      cfg_shift_en   <= 1'b0;
      cfg_mode       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bits_left_q    <= '0;
      bits_in_word_q <= '0;
      wait_q         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StError: begin
          if (start) begin
            state_q     <= StLoad;
            word_ready  <= 1'b1;
            cfg_mode    <= 1'b1;
            busy        <= 1'b1;
            error       <= 1'b0;
            rb_parity   <= 1'b0;
            bits_left_q <= BitsW'(CHAIN_LEN);
            wait_q      <= '0;
          end
        end
        StLoad: begin
          if (word_valid && word_ready) begin
            state_q        <= StShift;
            word_ready     <= 1'b0;
            cfg_shift_en   <= 1'b1;
            bits_in_word_q <= word_bits;
            wait_q         <= '0;
          end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
            state_q    <= StError;
            word_ready <= 1'b0;
            cfg_mode   <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            wait_q     <= '0;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StShift: begin
          rb_parity      <= rb_parity ^ chain_tail_in;
          bits_left_q    <= bits_left_q - BitsW'(1);
          bits_in_word_q <= bits_in_word_q - WordCntW'(1);
          if (bits_in_word_q == WordCntW'(1)) begin
            cfg_shift_en <= 1'b0;
            if (bits_left_q == BitsW'(1)) begin
              state_q  <= StDone;
              done     <= 1'b1;
              cfg_mode <= 1'b0;
              busy     <= 1'b0;
            end else begin
              state_q    <= StLoad;
              word_ready <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
